voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphony controller for the synth's bank of triangle wave generators.
- Accepts note-on/note-off requests over a valid/ready handshake and assigns each note to one of NUM_VOICES generator voices.
- Drives each voice's period and gate, and issues a phase-restart pulse to the chosen voice.
- When all voices are busy, steals the oldest sounding voice. Sits between the note input decoder and the per-voice wave generators / mixer.

Parameters:
NUM_VOICES, 4, number of generator voices managed (2..8)
PERIOD_W, 32, width of a voice period in clk cycles (matches wave generator period input)
NOTE_W, 7, width of note identifier
AGE_W, 8, width of per-voice age counter (saturating)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
in_on  input  1  1 = note-on, 0 = note-off
in_note  input  NOTE_W  note identifier
in_period  input  PERIOD_W  requested period for note-on (ignored for note-off)
voice_gate  output  NUM_VOICES  bit i high while voice i is sounding
voice_period  output  NUM_VOICES*PERIOD_W  voice i period at bits [i*PERIOD_W +: PERIOD_W]
voice_restart  output  NUM_VOICES  one-cycle pulse; generator i must clear its phase/step state
steal_pulse  output  1  one-cycle pulse coincident with voice_restart when a sounding voice was stolen
active_count  output  $clog2(NUM_VOICES)+1  popcount of voice_gate (combinational from registered gates)

Behaviour:
- Reset (reset==0 at a clk edge):
  - voice_gate, voice_period, voice_restart, steal_pulse, all ages and all stored notes clear to 0.
  - FSM goes to IDLE.
  - in_ready is 0 while reset is low.
  - Any request in flight is dropped with no output effect.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_on, in_note and the clamped period, then go to SCAN.
  - SCAN: in_ready=0. Evaluate the request and register target voice mask and action; go to COMMIT.
  - COMMIT: in_ready=0. Apply the action to voice registers; go to IDLE.
- Timing: a request accepted at edge E0 has its outputs visible after edge E2. voice_restart and steal_pulse are high for exactly the cycle after E2. in_ready returns to 1 after E2. Maximum throughput is one request per 3 cycles; in_valid held high without acceptance is simply held off.
- Period clamp: if in_period < 16, the stored period is 16 (the generator divides by 16); otherwise the period is stored unchanged.
- Note-on decision, priority order:
  - (1) Retrigger: if a gated voice already holds in_note, pick the lowest such index. Update its period, pulse restart, age=0, no steal.
  - (2) Free voice: otherwise pick the lowest-index voice with gate=0. Gate=1, store note/period, pulse restart, age=0.
  - (3) Steal: otherwise pick the gated voice with maximum age (ties → lowest index). Overwrite note/period, pulse restart and steal_pulse, age=0.
- Ages: on any note-on commit, every other gated voice's age increments by 1, saturating at 2^AGE_W-1. Ungated voices keep their age frozen; age is irrelevant while free.
- Note-off: every gated voice holding in_note gets gate=0. Period is retained so the generator output settles. No restart, no age change. An unmatched note-off is a no-op but still consumes the 3-cycle slot.
- voice_period changes only in COMMIT of a note-on; all other bits hold.
- Exactly one voice is affected by a note-on; note-off may clear several only if duplicates exist (not reachable via retrigger rule, but must be handled).
- Simultaneous events: none; the handshake serialises all requests.

Test Plan:
- Reset low 3 cycles with in_valid=1 → in_ready=0, voice_gate=0, voice_period all 0; release reset → in_ready=1 next cycle.
- Note-on note=60, period=48000 → after E2, voice_gate=4'b0001, voice 0 period=48000, voice_restart=4'b0001 for one cycle, active_count=1, in_ready low exactly 2 cycles.
- Note-ons 60,62,64,67 then 69 (periods 1000,2000,3000,4000,5000) → voices 0..3 fill in order; 5th steals voice 0 (age 3): voice 0 period=5000, steal_pulse=1, voice_gate stays 4'b1111.
- With 60 sounding on voice 0, note-on 60 period=10 → no new voice, voice 0 period=16 (clamped), restart pulse on voice 0, steal_pulse=0.
- Note-off 62 while 62 is on voice 1 → voice_gate bit1 cleared, voice 1 period unchanged, no restart; note-off 99 (not sounding) → no change, in_ready back after 2 cycles.
- Assert reset between acceptance and COMMIT of a note-on → after reset all gates 0; request never applied, no restart pulse.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off requests to generator voices, stealing the oldest voice when full
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W = 32,
  parameter int NOTE_W = 7,
  parameter int AGE_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_on,
  input  logic [NOTE_W-1:0] in_note,
  input  logic [PERIOD_W-1:0] in_period,
  output logic [NUM_VOICES-1:0] voice_gate,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES-1:0] voice_restart,
  output logic steal_pulse,
  output logic [$clog2(NUM_VOICES):0] active_count
);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_n;
  logic r_on, r_steal, sel_steal, any_hit, any_free;
  logic [NOTE_W-1:0] r_note;
  logic [PERIOD_W-1:0] r_period;
  logic [NUM_VOICES-1:0] tgt, sel, hit, free, old, offm;
  logic [AGE_W-1:0] best;
  logic [NOTE_W-1:0] note_q [NUM_VOICES];
  logic [AGE_W-1:0] age_q [NUM_VOICES];
  assign in_ready = reset && state == IDLE;
  always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (in_valid ? SCAN : IDLE) : state == SCAN ? COMMIT : IDLE;
  // Candidate masks for retrigger, free voice and oldest voice; note-off takes every match
  always_comb begin
    hit = '0;
    free = '0;
    offm = '0;
    old = '0;
    old[0] = 1'b1;
    best = age_q[0];
    any_hit = 1'b0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_gate[i] && note_q[i] == r_note) begin
        offm[i] = 1'b1;
        if (!any_hit) hit[i] = 1'b1;
        any_hit = 1'b1;
      end
      if (!voice_gate[i] && !any_free) begin
        free[i] = 1'b1;
        any_free = 1'b1;
      end
      if (i > 0 && age_q[i] > best) begin
        best = age_q[i];
        old = '0;
        old[i] = 1'b1;
      end
    end
    sel = !r_on ? offm : any_hit ? hit : any_free ? free : old;
    sel_steal = r_on && !any_hit && !any_free;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      voice_gate <= '0;
      voice_period <= '0;
      voice_restart <= '0;
      steal_pulse <= 1'b0;
      r_on <= 1'b0;
      r_steal <= 1'b0;
      r_note <= '0;
      r_period <= '0;
      tgt <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      voice_restart <= '0;
      steal_pulse <= 1'b0;
      if (in_valid && in_ready) begin
        r_on <= in_on;
        r_note <= in_note;
        r_period <= in_period < PERIOD_W'(16) ? PERIOD_W'(16) : in_period;
      end
      if (state == SCAN) begin
        tgt <= sel;
        r_steal <= sel_steal;
      end
      if (state == COMMIT) begin
        steal_pulse <= r_on && r_steal;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (tgt[i] && r_on) begin
            voice_gate[i] <= 1'b1;
            note_q[i] <= r_note;
            voice_period[i*PERIOD_W +: PERIOD_W] <= r_period;
            age_q[i] <= '0;
            voice_restart[i] <= 1'b1;
          end else if (tgt[i]) voice_gate[i] <= 1'b0;
          else if (r_on && voice_gate[i] && age_q[i] != '1) age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) active_count = active_count + {{$clog2(NUM_VOICES){1'b0}}, voice_gate[i]};
  end
endmodule
